// File: rtl/debug_dump_tx.sv
// debug_dump_tx: debug-port host for the MIPS core.
// Sweeps debug_addr from 0 to ADDR_LAST, captures each 32-bit debug_data word
// and streams it MSB byte first over an 8N1 UART line (LSB first within a byte).
// It also issues single-cycle debug_step pulses on request.
//
// Optional feature macro: DEBUG_DUMP_HEADER_EN
//   defined   -> every word is preceded by a header byte {1'b1, debug_addr}
//   undefined -> four raw data bytes per word
//
// fsm_state exposes the current FSM state for checkers and bring-up.
module debug_dump_tx #(
    parameter int CLK_DIV   = 868,  // clock cycles per UART bit, >= 2
    parameter int ADDR_LAST = 127,  // last debug address in a sweep, 0..127
    parameter int SETTLE    = 2     // cycles debug_addr is stable before sampling, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_req,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

`ifdef DEBUG_DUMP_HEADER_EN
    localparam int BYTES = 5;
`else
    localparam int BYTES = 4;
`endif

    localparam int WW = BYTES * 8;
    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] BIT_LAST    = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [6:0]    ADDR_END    = 7'(ADDR_LAST);
    localparam logic [2:0]    BYTE_LAST   = 3'(BYTES - 1);

    // Request protocol: start and step_req are level requests with no
    // acknowledge. They are looked at only while the FSM sits in IDLE; a
    // request seen in IDLE is accepted on that edge, step_req wins over start
    // and a losing or out-of-IDLE request is simply dropped, never queued.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_SETTLE    = 3'd2,
        S_LOAD      = 3'd3,
        S_START_BIT = 3'd4,
        S_DATA_BITS = 3'd5,
        S_STOP_BIT  = 3'd6,
        S_NEXT      = 3'd7
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [CW-1:0]  bit_cnt;     // cycles left in the current line bit
    logic [SW-1:0]  settle_cnt;  // cycles left before the word is sampled
    logic [2:0]     bit_idx;     // data bit being sent within the byte
    logic [2:0]     byte_idx;    // byte being sent within the word
    logic [WW-1:0]  word;        // captured word, current byte in the top 8 bits

    logic           bit_end;
    logic           last_byte;
    logic           in_line;
    logic [7:0]     cur_byte;
    logic [2:0]     tx_sel;
    logic           tx_next;
    logic           dumping_next;

    assign bit_end   = (bit_cnt == '0);
    assign last_byte = (byte_idx == BYTE_LAST);
    assign cur_byte  = word[WW-1 -: 8];
    assign in_line   = (state == S_START_BIT) || (state == S_DATA_BITS) ||
                       (state == S_STOP_BIT);
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the line value for the upcoming cycle.
    // The final stop bit of a word ends in NEXT, which keeps the line high,
    // so the NEXT bookkeeping cycle costs no extra line time.
    always_comb begin
        state_next   = state;
        tx_sel       = bit_idx;
        tx_next      = 1'b1;
        dumping_next = 1'b0;

        case (state)
            S_IDLE: begin
                if (step_req) begin
                    state_next = S_STEP;
                end else if (start) begin
                    state_next = S_SETTLE;
                end
            end
            S_STEP: begin
                state_next = S_IDLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_START_BIT;
            end
            S_START_BIT: begin
                if (bit_end) begin
                    state_next = S_DATA_BITS;
                end
            end
            S_DATA_BITS: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = S_STOP_BIT;
                end
            end
            S_STOP_BIT: begin
                if (last_byte && (bit_cnt == CW'(1))) begin
                    state_next = S_NEXT;
                end else if (!last_byte && bit_end) begin
                    state_next = S_START_BIT;
                end
            end
            S_NEXT: begin
                if (debug_addr == ADDR_END) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_SETTLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if ((state == S_DATA_BITS) && bit_end) begin
            tx_sel = bit_idx + 3'd1;
        end

        if (state_next == S_START_BIT) begin
            tx_next = 1'b0;
        end else if (state_next == S_DATA_BITS) begin
            tx_next = cur_byte[tx_sel];
        end

        dumping_next = (state_next != S_IDLE) && (state_next != S_STEP);
    end

    // Bit and settle timers: bit_cnt reloads at every bit boundary and idles
    // at full count; settle_cnt idles at full count and runs only in SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= BIT_LAST;
            settle_cnt <= SETTLE_LAST;
        end else begin
            if (in_line && !bit_end) begin
                bit_cnt <= bit_cnt - CW'(1);
            end else begin
                bit_cnt <= BIT_LAST;
            end

            if ((state == S_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SW'(1);
            end else begin
                settle_cnt <= SETTLE_LAST;
            end
        end
    end

    // Word capture, byte/bit sequencing and debug address sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx    <= '0;
            byte_idx   <= '0;
            word       <= '0;
            debug_addr <= '0;
        end else begin
            if (state == S_START_BIT) begin
                bit_idx <= '0;
            end else if ((state == S_DATA_BITS) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == S_LOAD) begin
                byte_idx <= '0;
`ifdef DEBUG_DUMP_HEADER_EN
                word     <= {1'b1, debug_addr, debug_data};
`else
                word     <= debug_data;
`endif
            end else if ((state == S_STOP_BIT) && bit_end && !last_byte) begin
                byte_idx <= byte_idx + 3'd1;
                word     <= word << 8;
            end

            if ((state == S_IDLE) && start && !step_req) begin
                debug_addr <= '0;
            end else if ((state == S_NEXT) && (debug_addr != ADDR_END)) begin
                debug_addr <= debug_addr + 7'd1;
            end
        end
    end

    // Registered outputs, driven from the next state so each lines up with
    // the state it belongs to and none of them can glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            debug_en   <= 1'b0;
            debug_step <= 1'b0;
        end else begin
            uart_tx    <= tx_next;
            busy       <= dumping_next;
            done       <= (state == S_NEXT) && (state_next == S_IDLE);
            debug_en   <= dumping_next || (state_next == S_STEP);
            debug_step <= (state_next == S_STEP);
        end
    end

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Debug-port host for the MIPS core. It drives the core's debug inputs (`debug_en`, `debug_step`, `debug_addr`) and reads the core's `debug_data` output. On request it sweeps `debug_addr` from 0 to `ADDR_LAST`, captures each 32-bit word and streams it out over a UART TX line (8N1). It also issues single-step pulses. It sits at board top level, between `mips` and the FPGA serial pin.

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit, minimum 2 (868 gives 115200 baud at 100 MHz).
- `ADDR_LAST`, default 127: last debug address in a sweep, range 0..127.
- `SETTLE`, default 2: cycles `debug_addr` is held stable before `debug_data` is sampled, minimum 1.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a full dump; sampled in IDLE only.
- `step_req`  in  1  request one `debug_step` pulse; sampled in IDLE only.
- `debug_en`  out  1  to core; high throughout a dump and during a step pulse.
- `debug_step`  out  1  to core; single-cycle step pulse.
- `debug_addr`  out  7  to core; address being read.
- `debug_data`  in  32  from core; word at `debug_addr`.
- `uart_tx`  out  1  serial output; idles high.
- `busy`  out  1  high from the cycle after an accepted `start` until the last stop bit completes.
- `done`  out  1  one-cycle pulse when a dump completes.

## Operation
- States: IDLE, STEP, SETTLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE:
  - If `step_req` is high, go to STEP.
  - Else if `start` is high, go to SETTLE with `debug_addr`=0.
  - If both are high in the same cycle, the step is taken and `start` is dropped (not queued).
- STEP: `debug_en`=1 and `debug_step`=1 for exactly one cycle, then return to IDLE.
- SETTLE: wait `SETTLE` cycles with `debug_addr` constant, then go to LOAD.
- LOAD: latch `debug_data` into a shift register, reset the byte index, go to START_BIT.
- Byte order within a word: MSB first (bits 31:24, 23:16, 15:8, 7:0).
- Bit order within a byte: LSB first. Framing: 1 start bit (0), 8 data bits, 1 stop bit (1).
- Every bit lasts exactly `CLK_DIV` cycles. Use a down-counter of width `$clog2(CLK_DIV)`, reloaded at each bit boundary.
- After the stop bit:
  - If bytes remain in the word, go to START_BIT.
  - Else go to NEXT.
- NEXT:
  - If `debug_addr`==`ADDR_LAST`, go to IDLE, pulse `done`, and drop `busy`.
  - Else increment `debug_addr` and go to SETTLE.
  - `debug_addr` never wraps: 127 is terminal.
- `start` and `step_req` are ignored whenever the FSM is not in IDLE.
- `debug_data` is sampled only in LOAD. Changes at any other time have no effect on the transmitted word.

## Timing
- Reset values: `debug_en`=0, `debug_step`=0, `debug_addr`=0, `uart_tx`=1, `busy`=0, `done`=0; FSM in IDLE.
- `start` accepted at edge N:
  - At edge N+1: `busy`=1, `debug_en`=1, `debug_addr`=0.
  - Sample taken at edge N+1+`SETTLE`.
  - Start bit appears on `uart_tx` one cycle after the sample.
- Each word occupies `SETTLE`+1 setup cycles plus B×10×`CLK_DIV` line cycles, where B=4.
- `done` is high for one cycle, coincident with `busy` falling, on the cycle after the last stop bit ends.
- `debug_en` falls in the same cycle as `busy`.
- `rst` mid-operation:
  - Next edge restores all reset values. `uart_tx` returns high and the partial frame is abandoned.
  - No `done` pulse is produced.
- `uart_tx` is registered and glitch-free.

## Configuration
- `DEBUG_DUMP_HEADER_EN`:
  - Defined: each word is preceded by a header byte `{1'b1, debug_addr}`, sent with the same framing. B=5.
  - Undefined: raw 4 bytes per word only. B=4.

## Test plan
Bench parameters: `CLK_DIV`=4, `ADDR_LAST`=1, `SETTLE`=2 unless stated.
1. Reset 2 cycles, then release -> all outputs at reset values; `uart_tx`=1 held for 50 cycles with no input activity.
2. `start` pulse; model returns 0x12345678 at addr 0 and 0xDEADBEEF at addr 1 -> decoded bytes 12,34,56,78,DE,AD,BE,EF:
   - each bit exactly 4 cycles;
   - one `done` pulse;
   - `busy` high for 2×(3+160)=326 cycles.
3. `step_req` in IDLE -> `debug_step`=1 for exactly 1 cycle with `debug_en`=1. `step_req` asserted during a dump -> no `debug_step` pulse; `start` asserted mid-dump -> no restart.
4. `start` and `step_req` in the same cycle -> one step pulse, no dump, `busy` stays 0.
5. `rst` during a data bit of byte 2 -> next cycle `uart_tx`=1, `busy`=0, `debug_addr`=0. A following `start` produces a complete, correct dump.
6. With `DEBUG_DUMP_HEADER_EN` -> byte stream 80,12,34,56,78,81,DE,AD,BE,EF; `busy` high 2×(3+200)=406 cycles.
